spi_slave_ctrl: RTL and testbench
=================================

// Module: spi_slave_ctrl
// PURPOSE
//  Parametrised SPI slave transaction controller. Successor to the fixed 7-bit-address /
//  8-bit-data slave FSM. Counter-driven frame decode with configurable widths and
//  optional burst (auto-increment) mode. Sits between the input conditioners
//  (cs, mosi, sclk edge pulses) and the synchronous data memory; drives the MISO bit and
//  its output-enable to the external tri-state buffer.
// PARAMETERS
//  ADDR_W  7  address bits per frame, MSB first
//  DATA_W  8  data bits per word, MSB first
//  BURST   1  1: words continue at addr+1 until cs rises; 0: one word per frame
// PORTS
//  clk        in   1       system clock; all logic on posedge
//  reset_n    in   1       asynchronous, active-low reset
//  cs         in   1       conditioned chip select, active low
//  sclk_pe    in   1       one-clk pulse per SCLK rising edge (sample edge)
//  sclk_ne    in   1       one-clk pulse per SCLK falling edge (shift-out edge)
//  mosi       in   1       conditioned serial data in
//  miso       out  1       serial data out; 0 when miso_oe=0
//  miso_oe    out  1       enable for MISO tri-state buffer
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_we     out  1       one-clk write strobe
//  mem_re     out  1       one-clk read strobe; mem_rdata valid the following clk
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 whenever state != IDLE
//  frame_err  out  1       one-clk pulse: cs rose mid-word
// BEHAVIOUR
//  Reset (reset_n=0): state IDLE; all outputs 0; shift regs and bit counter cleared.
//  Frame: ADDR_W addr bits, 1 R/W bit (1=read, 0=write), then DATA_W-bit data words.
//  States: IDLE, ADDR, RW, RD, WR, DONE. bitcnt counts sclk_pe within the current field.
//  - IDLE: cs=0 -> ADDR, bitcnt=0. sclk pulses are ignored while cs=1.
//  - ADDR: each sclk_pe shifts mosi into addr reg; on the ADDR_W-th pulse -> RW.
//  - RW: sclk_pe captures rw. rw=0 -> WR. rw=1 -> RD; mem_re=1 on the next clk.
//  - RD: tx_sr is loaded from mem_rdata on the clk after mem_re; miso_oe=1 from then on.
//    miso = tx_sr MSB. sclk_ne shifts tx_sr left only when bitcnt!=0. The DATA_W-th
//    sclk_pe ends the word.
//  - WR: sclk_pe shifts mosi into rx_sr. The DATA_W-th pulse latches mem_wdata;
//    mem_we=1 on the next clk for exactly one clk, with mem_addr held stable.
//  - Word end, BURST=1: after the strobe, mem_addr <= mem_addr+1 (mod 2^ADDR_W).
//    RD issues mem_re for the new address on the clk after the word-ending sclk_pe.
//  - Word end, BURST=0: -> DONE. Further sclk pulses are ignored and no strobes issue.
//  - miso_oe stays 1 in RD/DONE-after-read until cs rises.
//  - Timing requirement: SCLK half-period >= 3 clk, so tx_sr is loaded before the next sclk_ne.
//  - cs rising (any non-IDLE state): -> IDLE next clk; miso_oe=0 next clk.
//    frame_err pulses if bitcnt != 0 in ADDR/RW/RD/WR. A partial write word is discarded.
//  - Simultaneous sclk_pe and cs rise: the pulse is processed first, then -> IDLE.
//    A word completed by that pulse still writes.
//  - mem_we and mem_re never assert in the same clk and never assert outside a frame.
//  - reset_n low mid-frame clears immediately. A pending strobe is dropped.
// TESTING
//  1 Write: addr 7'h2A, rw=0, data 8'hC5 -> single mem_we 1 clk after the 16th sclk_pe,
//    with mem_addr=2A and mem_wdata=C5; miso_oe=0 throughout.
//  2 Read: mem[2A]=8'h3C; addr 2A, rw=1 -> one mem_re after the 8th pe;
//    master samples 0,0,1,1,1,1,0,0 on pe 9-16; miso_oe=1 until cs high.
//  3 Burst write wrap: addr 7'h7F, data AA then 55 -> writes mem[7F]=AA, mem[00]=55.
//  4 BURST=0: same two-word frame -> only mem[7F]=AA is written; busy=1 until cs rises.
//  5 Abort: cs rises after 4 data bits of a write -> no mem_we, one frame_err pulse, IDLE;
//    the next full frame completes correctly.
//  6 reset_n low mid-read -> miso_oe, mem_re, busy=0 asynchronously;
//    after release, a normal read frame passes.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave transaction controller: decodes addr / R/W / data-word frames from
// conditioned SCLK edge pulses and drives a synchronous memory plus the MISO driver.
module spi_slave_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int BURST  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cs,
   input  logic              sclk_pe,
   input  logic              sclk_ne,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              frame_err
);

   localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, ADDR, RW, RD, WR, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  bitcnt;
   logic [CNT_W-1:0]  bitcnt_after;
   logic [ADDR_W-1:0] addr_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [DATA_W-1:0] tx_sr;
   logic              load_pend;
   logic              wr_done;
   logic              abort_err;

   // Field bit count after the current sclk_pe; lets a cs rise coinciding with a
   // word-ending pulse see the completed word rather than a partial one.
   always_comb begin
      bitcnt_after = bitcnt;
      if (sclk_pe) begin
         case (state)
            ADDR:    bitcnt_after = (bitcnt == ADDR_LAST) ? '0 : bitcnt + 1'b1;
            RD, WR:  bitcnt_after = (bitcnt == DATA_LAST) ? '0 : bitcnt + 1'b1;
            default: bitcnt_after = bitcnt;
         endcase
      end
   end

   assign wr_done   = (state == WR) && sclk_pe && (bitcnt == DATA_LAST);
   assign abort_err = (state == ADDR || state == RW || state == RD || state == WR) &&
                      (bitcnt_after != '0);
   assign busy      = (state != IDLE);
   assign miso      = miso_oe & tx_sr[DATA_W-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         bitcnt    <= '0;
         addr_sr   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         load_pend <= 1'b0;
         miso_oe   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         frame_err <= 1'b0;
         load_pend <= mem_re;
         if (mem_we && BURST != 0) mem_addr <= mem_addr + 1'b1;

         // Read data arrives the clk after mem_re; a load outranks a shift.
         if (load_pend) begin
            tx_sr   <= mem_rdata;
            miso_oe <= 1'b1;
         end else if (state == RD && sclk_ne && bitcnt != '0) begin
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
         end

         if (state != IDLE && cs) begin
            state     <= IDLE;
            bitcnt    <= '0;
            miso_oe   <= 1'b0;
            load_pend <= 1'b0;
            frame_err <= abort_err;
            if (wr_done) begin
               mem_wdata <= {rx_sr[DATA_W-2:0], mosi};
               mem_we    <= 1'b1;
            end
         end else begin
            case (state)
               IDLE: if (!cs) begin
                  state  <= ADDR;
                  bitcnt <= '0;
               end
               ADDR: if (sclk_pe) begin
                  addr_sr <= {addr_sr[ADDR_W-2:0], mosi};
                  bitcnt  <= bitcnt_after;
                  if (bitcnt == ADDR_LAST) begin
                     mem_addr <= {addr_sr[ADDR_W-2:0], mosi};
                     state    <= RW;
                  end
               end
               RW: if (sclk_pe) begin
                  if (mosi) begin
                     state  <= RD;
                     mem_re <= 1'b1;
                  end else begin
                     state <= WR;
                  end
               end
               RD: if (sclk_pe) begin
                  bitcnt <= bitcnt_after;
                  if (bitcnt == DATA_LAST) begin
                     if (BURST != 0) begin
                        mem_addr <= mem_addr + 1'b1;
                        mem_re   <= 1'b1;
                     end else begin
                        state <= DONE;
                     end
                  end
               end
               WR: if (sclk_pe) begin
                  bitcnt <= bitcnt_after;
                  if (wr_done) begin
                     mem_wdata <= {rx_sr[DATA_W-2:0], mosi};
                     mem_we    <= 1'b1;
                     if (BURST == 0) state <= DONE;
                  end else begin
                     rx_sr <= {rx_sr[DATA_W-2:0], mosi};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboarded bench: BURST=1 and BURST=0 controllers share one SPI master; expected
// memory strobes are queued per instance and popped by a negedge monitor.
module tb_spi_slave_ctrl;

   typedef enum logic [1:0] {EV_WE, EV_RE, EV_ERR} kind_t;
   typedef struct {
      kind_t      kind;
      logic [6:0] addr;
      logic [7:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n, cs, sclk_pe, sclk_ne, mosi;
   logic miso1, oe1, we1, re1, busy1, err1;
   logic miso0, oe0, we0, re0, busy0, err0;
   logic [6:0] addr1, addr0;
   logic [7:0] wdata1, wdata0, rdata1, rdata0;
   logic [7:0] mem1 [128];
   logic [7:0] mem0 [128];
   logic       pl_en;
   logic [6:0] pl_a;
   logic [7:0] pl_d;
   logic       pe_q;

   ev_t q1[$];
   ev_t q0[$];
   int  tests = 0;
   int  fails = 0;

   logic [15:0] rd1, rd0;
   logic s1, s0, so1, so0, oe_and1, oe_and0, oe_or1, oe_or0, busy_pre0, oe_pre1, oe_pre0;

   always #5 clk = ~clk;

   spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(1)) u_b1 (
      .clk(clk), .reset_n(reset_n), .cs(cs), .sclk_pe(sclk_pe), .sclk_ne(sclk_ne),
      .mosi(mosi), .miso(miso1), .miso_oe(oe1), .mem_addr(addr1), .mem_wdata(wdata1),
      .mem_we(we1), .mem_re(re1), .mem_rdata(rdata1), .busy(busy1), .frame_err(err1));

   spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST(0)) u_b0 (
      .clk(clk), .reset_n(reset_n), .cs(cs), .sclk_pe(sclk_pe), .sclk_ne(sclk_ne),
      .mosi(mosi), .miso(miso0), .miso_oe(oe0), .mem_addr(addr0), .mem_wdata(wdata0),
      .mem_we(we0), .mem_re(re0), .mem_rdata(rdata0), .busy(busy0), .frame_err(err0));

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem1[i] = 8'h00;
         mem0[i] = 8'h00;
      end
   end

   // Synchronous memories; preload port lets the bench seed contents.
   always @(posedge clk) begin
      pe_q <= sclk_pe;
      if (pl_en) begin
         mem1[pl_a] <= pl_d;
         mem0[pl_a] <= pl_d;
      end
      if (we1) mem1[addr1] <= wdata1;
      if (re1) rdata1 <= mem1[addr1];
      if (we0) mem0[addr0] <= wdata0;
      if (re0) rdata0 <= mem0[addr0];
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic pop_cmp(input int inst, input kind_t k, input logic [6:0] a,
                          input logic [7:0] d);
      ev_t e;
      tests++;
      if ((inst == 1 && q1.size() == 0) || (inst == 0 && q0.size() == 0)) begin
         fails++;
         $display("FAIL unexpected_event inst%0d: got kind %0d addr %0h data %0h expected none",
                  inst, k, a, d);
         return;
      end
      e = (inst == 1) ? q1.pop_front() : q0.pop_front();
      if (e.kind !== k || (k != EV_ERR && e.addr !== a) || (k == EV_WE && e.data !== d) ||
          (k != EV_ERR && pe_q !== 1'b1)) begin
         fails++;
         $display("FAIL event inst%0d: got kind %0d addr %0h data %0h pe_prev %0b expected kind %0d addr %0h data %0h pe_prev 1",
                  inst, k, a, d, pe_q, e.kind, e.addr, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (we1) pop_cmp(1, EV_WE, addr1, wdata1);
      if (re1) pop_cmp(1, EV_RE, addr1, 8'h00);
      if (err1) pop_cmp(1, EV_ERR, 7'h00, 8'h00);
      if (we0) pop_cmp(0, EV_WE, addr0, wdata0);
      if (re0) pop_cmp(0, EV_RE, addr0, 8'h00);
      if (err0) pop_cmp(0, EV_ERR, 7'h00, 8'h00);
   end

   task automatic push(input int inst, input kind_t k, input logic [6:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      if (inst == 1) q1.push_back(e);
      else q0.push_back(e);
   endtask

   task automatic preload(input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // One SCLK period: master samples MISO as it raises SCLK, shifts on the fall.
   task automatic send(input logic b);
      @(negedge clk);
      mosi = b; sclk_pe = 1'b1;
      s1 = miso1; s0 = miso0; so1 = oe1; so0 = oe0;
      @(negedge clk);
      sclk_pe = 1'b0;
      repeat (3) @(negedge clk);
      sclk_ne = 1'b1;
      @(negedge clk);
      sclk_ne = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic frame(input logic [6:0] a, input logic rw, input int nbits,
                        input logic [15:0] data, input bit end_cs);
      rd1 = '0; rd0 = '0;
      oe_and1 = 1'b1; oe_and0 = 1'b1; oe_or1 = 1'b0; oe_or0 = 1'b0;
      @(negedge clk);
      cs = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         send(i < 7 ? a[6-i] : rw);
         oe_or1 |= so1; oe_or0 |= so0;
      end
      for (int i = 0; i < nbits; i++) begin
         send(data[15-i]);
         rd1 = {rd1[14:0], s1}; rd0 = {rd0[14:0], s0};
         oe_and1 &= so1; oe_and0 &= so0;
         oe_or1 |= so1; oe_or0 |= so0;
      end
      busy_pre0 = busy0; oe_pre1 = oe1; oe_pre0 = oe0;
      if (end_cs) begin
         @(negedge clk);
         cs = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; cs = 1'b1; sclk_pe = 1'b0; sclk_ne = 1'b0; mosi = 1'b0;
      pl_en = 1'b0; pl_a = '0; pl_d = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs_b1", {miso1, oe1, we1, re1, busy1, err1, addr1, wdata1}, 32'h0);
      chk("reset_outputs_b0", {miso0, oe0, we0, re0, busy0, err0, addr0, wdata0}, 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // single write
      push(1, EV_WE, 7'h2A, 8'hC5);
      push(0, EV_WE, 7'h2A, 8'hC5);
      frame(7'h2A, 1'b0, 8, 16'hC500, 1'b1);
      chk("write_oe_low_b1", oe_or1, 1'b0);
      chk("write_mem_b1", mem1[7'h2A], 8'hC5);
      chk("write_mem_b0", mem0[7'h2A], 8'hC5);

      // single read; burst instance prefetches the next address
      preload(7'h2A, 8'h3C);
      push(1, EV_RE, 7'h2A, 8'h00);
      push(1, EV_RE, 7'h2B, 8'h00);
      push(0, EV_RE, 7'h2A, 8'h00);
      frame(7'h2A, 1'b1, 8, 16'h0000, 1'b1);
      chk("read_bits_b1", rd1[7:0], 8'h3C);
      chk("read_bits_b0", rd0[7:0], 8'h3C);
      chk("read_oe_during_b1", oe_and1, 1'b1);
      chk("read_oe_before_cs_b0", oe_pre0, 1'b1);
      chk("read_oe_after_cs_b1", oe1, 1'b0);
      chk("read_oe_after_cs_b0", oe0, 1'b0);

      // two-word write at 7F: burst wraps to 00, single-word mode stops after one
      push(1, EV_WE, 7'h7F, 8'hAA);
      push(1, EV_WE, 7'h00, 8'h55);
      push(0, EV_WE, 7'h7F, 8'hAA);
      frame(7'h7F, 1'b0, 16, 16'hAA55, 1'b1);
      chk("burst_mem7f_b1", mem1[7'h7F], 8'hAA);
      chk("burst_mem00_b1", mem1[7'h00], 8'h55);
      chk("noburst_mem7f_b0", mem0[7'h7F], 8'hAA);
      chk("noburst_mem00_b0", mem0[7'h00], 8'h00);
      chk("noburst_busy_b0", busy_pre0, 1'b1);
      chk("idle_after_cs_b0", busy0, 1'b0);

      // abort mid-word, then a clean frame
      push(1, EV_ERR, 7'h00, 8'h00);
      push(0, EV_ERR, 7'h00, 8'h00);
      frame(7'h10, 1'b0, 4, 16'hA000, 1'b1);
      chk("abort_idle_b1", busy1, 1'b0);
      chk("abort_nowrite_b1", mem1[7'h10], 8'h00);
      push(1, EV_WE, 7'h10, 8'h5A);
      push(0, EV_WE, 7'h10, 8'h5A);
      frame(7'h10, 1'b0, 8, 16'h5A00, 1'b1);
      chk("post_abort_mem_b1", mem1[7'h10], 8'h5A);
      chk("post_abort_mem_b0", mem0[7'h10], 8'h5A);

      // reset mid-read, then a normal read
      preload(7'h40, 8'h96);
      push(1, EV_RE, 7'h40, 8'h00);
      push(0, EV_RE, 7'h40, 8'h00);
      frame(7'h40, 1'b1, 3, 16'h0000, 1'b0);
      chk("midread_oe_b1", oe1, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_b1", {oe1, re1, busy1}, 3'b000);
      chk("async_reset_b0", {oe0, re0, busy0}, 3'b000);
      @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      push(1, EV_RE, 7'h40, 8'h00);
      push(1, EV_RE, 7'h41, 8'h00);
      push(0, EV_RE, 7'h40, 8'h00);
      frame(7'h40, 1'b1, 8, 16'h0000, 1'b1);
      chk("post_reset_read_b1", rd1[7:0], 8'h96);
      chk("post_reset_read_b0", rd0[7:0], 8'h96);

      repeat (4) @(negedge clk);
      chk("events_drained_b1", q1.size(), 0);
      chk("events_drained_b0", q0.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
